// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding / load-use hazard unit: tracks in-flight writers after ID, raises a
// combinational load-use stall and registers per-source EX forward selects.
module fwd_hazard_scoreboard #(
  parameter int REG_AW    = 5,
  parameter int DEPTH     = 3,
  parameter int NUM_SRC   = 2,
  parameter int LOAD_SLOT = 1,
  parameter int CNT_W     = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              hold_i,
  input  logic                              flush_i,
  input  logic                              id_valid_i,
  input  logic [REG_AW-1:0]                 id_rd_i,
  input  logic                              id_regwr_i,
  input  logic                              id_memrd_i,
  input  logic [NUM_SRC*REG_AW-1:0]         id_rs_i,
  input  logic [NUM_SRC-1:0]                id_rs_use_i,
  output logic                              stall_o,
  output logic [NUM_SRC*$clog2(DEPTH)-1:0]  ex_fwd_o,
  output logic [CNT_W-1:0]                  stall_cnt_o
);

  localparam int SEL_W = $clog2(DEPTH);
  // The write-back slot is never a forwarding source (regfile is write-through),
  // so only slots 0..DEPTH-2 carry state.
  localparam int TRK = DEPTH - 1;

  logic [TRK-1:0]                valid_q, valid_d;
  logic [TRK-1:0]                regwr_q, regwr_d;
  logic [TRK-1:0]                memrd_q, memrd_d;
  logic [TRK-1:0][REG_AW-1:0]    rd_q, rd_d;
  logic [NUM_SRC*SEL_W-1:0]      ex_fwd_q, ex_fwd_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  logic [TRK-1:0]                live_s;
  logic [NUM_SRC-1:0][REG_AW-1:0] rs_s;
  logic [NUM_SRC-1:0]            need_s;
  logic [NUM_SRC-1:0]            stall_req_s;
  logic [NUM_SRC-1:0][SEL_W-1:0] sel_s;
  logic                          stall_s;
  logic                          advance_s;

  // Live writers: valid, writing, and not targeting x0.
  always_comb begin
    live_s = '0;
    for (int k = 0; k < TRK; k++) begin
      live_s[k] = valid_q[k] & regwr_q[k] & (rd_q[k] != {REG_AW{1'b0}});
    end
  end

  // Per-source lookup; slots scanned oldest-first so the youngest match overrides.
  always_comb begin
    rs_s        = '0;
    need_s      = '0;
    stall_req_s = '0;
    sel_s       = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs_s[i]   = id_rs_i[i*REG_AW +: REG_AW];
      need_s[i] = id_valid_i & id_rs_use_i[i] & (rs_s[i] != {REG_AW{1'b0}});
      for (int k = TRK - 1; k >= 0; k--) begin
        stall_req_s[i] = (need_s[i] && live_s[k] && (rd_q[k] == rs_s[i]))
                         ? (memrd_q[k] && (k < LOAD_SLOT))
                         : stall_req_s[i];
        sel_s[i]       = (need_s[i] && live_s[k] && (rd_q[k] == rs_s[i]))
                         ? ((memrd_q[k] && (k < LOAD_SLOT)) ? {SEL_W{1'b0}} : SEL_W'(k + 1))
                         : sel_s[i];
      end
    end
  end

  // Stall request; a flushed ID instruction never stalls.
  always_comb begin
    stall_s   = (|stall_req_s) & ~flush_i;
    advance_s = ~stall_s & ~flush_i;
  end

  // Next state: shift the pipeline, insert ID or a bubble, update selects and counter.
  always_comb begin
    valid_d  = valid_q;
    regwr_d  = regwr_q;
    memrd_d  = memrd_q;
    rd_d     = rd_q;
    ex_fwd_d = ex_fwd_q;
    cnt_d    = cnt_q;
    if (hold_i) begin
      cnt_d = cnt_q;
    end else begin
      for (int k = 1; k < TRK; k++) begin
        valid_d[k] = valid_q[k-1];
        regwr_d[k] = regwr_q[k-1];
        memrd_d[k] = memrd_q[k-1];
        rd_d[k]    = rd_q[k-1];
      end
      if (advance_s) begin
        valid_d[0] = id_valid_i;
        regwr_d[0] = id_regwr_i;
        memrd_d[0] = id_memrd_i;
        rd_d[0]    = id_rd_i;
      end else begin
        valid_d[0] = 1'b0;
        regwr_d[0] = 1'b0;
        memrd_d[0] = 1'b0;
        rd_d[0]    = {REG_AW{1'b0}};
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        ex_fwd_d[i*SEL_W +: SEL_W] = advance_s ? sel_s[i] : {SEL_W{1'b0}};
      end
      if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      regwr_q  <= '0;
      memrd_q  <= '0;
      rd_q     <= '0;
      ex_fwd_q <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      regwr_q  <= regwr_d;
      memrd_q  <= memrd_d;
      rd_q     <= rd_d;
      ex_fwd_q <= ex_fwd_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stall_o     = stall_s;
  assign ex_fwd_o    = ex_fwd_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard: default config, DEPTH=4/LOAD_SLOT=2, and CNT_W=4
// instances share the same stimulus; each test checks the instance it targets.
module tb_fwd_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst, hold, flush, id_valid, id_regwr, id_memrd;
  logic [4:0]  id_rd;
  logic [9:0]  id_rs;
  logic [1:0]  id_use;

  logic        stall_s, stall2, stall3;
  logic [3:0]  fwd_s, fwd2, fwd3;
  logic [31:0] cnt_s, cnt2;
  logic [3:0]  cnt3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fwd_hazard_scoreboard dut (
    .clk(clk), .rst(rst), .hold_i(hold), .flush_i(flush), .id_valid_i(id_valid),
    .id_rd_i(id_rd), .id_regwr_i(id_regwr), .id_memrd_i(id_memrd), .id_rs_i(id_rs),
    .id_rs_use_i(id_use), .stall_o(stall_s), .ex_fwd_o(fwd_s), .stall_cnt_o(cnt_s));

  fwd_hazard_scoreboard #(.DEPTH(4), .LOAD_SLOT(2)) dut2 (
    .clk(clk), .rst(rst), .hold_i(hold), .flush_i(flush), .id_valid_i(id_valid),
    .id_rd_i(id_rd), .id_regwr_i(id_regwr), .id_memrd_i(id_memrd), .id_rs_i(id_rs),
    .id_rs_use_i(id_use), .stall_o(stall2), .ex_fwd_o(fwd2), .stall_cnt_o(cnt2));

  fwd_hazard_scoreboard #(.CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .hold_i(hold), .flush_i(flush), .id_valid_i(id_valid),
    .id_rd_i(id_rd), .id_regwr_i(id_regwr), .id_memrd_i(id_memrd), .id_rs_i(id_rs),
    .id_rs_use_i(id_use), .stall_o(stall3), .ex_fwd_o(fwd3), .stall_cnt_o(cnt3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                        input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] u);
    id_valid = v; id_rd = rd; id_regwr = wr; id_memrd = ld; id_rs = {r1, r0}; id_use = u;
    #1;
  endtask

  task automatic do_reset();
    hold = 1'b0; flush = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (stall_s !== 1'b0) begin fails++; $display("FAIL reset_stall got %0b exp 0", stall_s); end
    tests++; if (fwd_s !== 4'd0) begin fails++; $display("FAIL reset_fwd got %0h exp 0", fwd_s); end
    tests++; if (cnt_s !== 32'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", cnt_s); end
  endtask

  task automatic test_fwd_ex();
    do_reset();
    set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11); step();
    set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd0, 2'b11);
    tests++; if (stall_s !== 1'b0) begin fails++; $display("FAIL ex_stall got %0b exp 0", stall_s); end
    step();
    tests++; if (fwd_s !== 4'b0001) begin fails++; $display("FAIL ex_fwd got %0h exp 1", fwd_s); end
    tests++; if (cnt_s !== 32'd0) begin fails++; $display("FAIL ex_cnt got %0d exp 0", cnt_s); end
  endtask

  task automatic test_fwd_mem_wb();
    do_reset();
    set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00); step();
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00); step();
    set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd0, 2'b01); step();
    tests++; if (fwd_s !== 4'b0010) begin fails++; $display("FAIL mem_fwd got %0h exp 2", fwd_s); end
    do_reset();
    set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00); step();
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00); step(); step();
    set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd0, 2'b01);
    tests++; if (stall_s !== 1'b0) begin fails++; $display("FAIL wb_stall got %0b exp 0", stall_s); end
    step();
    tests++; if (fwd_s !== 4'b0000) begin fails++; $display("FAIL wb_fwd got %0h exp 0", fwd_s); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); step();
    set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd7, 2'b11);
    tests++; if (stall_s !== 1'b1) begin fails++; $display("FAIL lu1_stall_a got %0b exp 1", stall_s); end
    step();
    tests++; if (stall_s !== 1'b0) begin fails++; $display("FAIL lu1_stall_b got %0b exp 0", stall_s); end
    step();
    tests++; if (fwd_s !== 4'b1010) begin fails++; $display("FAIL lu1_fwd got %0h exp a", fwd_s); end
    tests++; if (cnt_s !== 32'd1) begin fails++; $display("FAIL lu1_cnt got %0d exp 1", cnt_s); end
  endtask

  task automatic test_load_use_l2();
    do_reset();
    set_id(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); step();
    set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd7, 2'b11);
    tests++; if (stall2 !== 1'b1) begin fails++; $display("FAIL lu2_stall_a got %0b exp 1", stall2); end
    step();
    tests++; if (stall2 !== 1'b1) begin fails++; $display("FAIL lu2_stall_b got %0b exp 1", stall2); end
    step();
    tests++; if (stall2 !== 1'b0) begin fails++; $display("FAIL lu2_stall_c got %0b exp 0", stall2); end
    step();
    tests++; if (fwd2 !== 4'b1111) begin fails++; $display("FAIL lu2_fwd got %0h exp f", fwd2); end
    tests++; if (cnt2 !== 32'd2) begin fails++; $display("FAIL lu2_cnt got %0d exp 2", cnt2); end
  endtask

  task automatic test_youngest();
    do_reset();
    set_id(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00); step();
    set_id(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); step();
    set_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01);
    tests++; if (stall_s !== 1'b1) begin fails++; $display("FAIL yw_stall got %0b exp 1", stall_s); end
    step();
    tests++; if (stall_s !== 1'b0) begin fails++; $display("FAIL yw_stall_clr got %0b exp 0", stall_s); end
    step();
    tests++; if (fwd_s !== 4'b0010) begin fails++; $display("FAIL yw_fwd got %0h exp 2", fwd_s); end
  endtask

  task automatic test_flush();
    do_reset();
    set_id(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); step();
    flush = 1'b1;
    set_id(1'b1, 5'd4, 1'b1, 1'b0, 5'd4, 5'd0, 2'b01);
    tests++; if (stall_s !== 1'b0) begin fails++; $display("FAIL fl_stall got %0b exp 0", stall_s); end
    step();
    flush = 1'b0;
    tests++; if (fwd_s !== 4'd0) begin fails++; $display("FAIL fl_fwd got %0h exp 0", fwd_s); end
    set_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd4, 5'd0, 2'b01);
    tests++; if (stall_s !== 1'b0) begin fails++; $display("FAIL fl_next_stall got %0b exp 0", stall_s); end
    step();
    tests++; if (fwd_s !== 4'b0010) begin fails++; $display("FAIL fl_bubble got %0h exp 2", fwd_s); end
  endtask

  task automatic test_hold();
    do_reset();
    set_id(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); step();
    set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd0, 2'b01);
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tests++; if (stall_s !== 1'b1) begin fails++; $display("FAIL hold_stall[%0d] got %0b exp 1", c, stall_s); end
      step();
    end
    tests++; if (cnt_s !== 32'd0) begin fails++; $display("FAIL hold_cnt got %0d exp 0", cnt_s); end
    hold = 1'b0; #1;
    tests++; if (stall_s !== 1'b1) begin fails++; $display("FAIL hold_rel_stall got %0b exp 1", stall_s); end
    step();
    tests++; if (cnt_s !== 32'd1) begin fails++; $display("FAIL hold_rel_cnt got %0d exp 1", cnt_s); end
    tests++; if (stall_s !== 1'b0) begin fails++; $display("FAIL hold_clr got %0b exp 0", stall_s); end
    step();
    tests++; if (fwd_s !== 4'b0010) begin fails++; $display("FAIL hold_fwd got %0h exp 2", fwd_s); end
  endtask

  task automatic test_x0_and_use();
    do_reset();
    set_id(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); step();
    set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 5'd0, 2'b11);
    tests++; if (stall_s !== 1'b0) begin fails++; $display("FAIL x0_stall got %0b exp 0", stall_s); end
    step();
    tests++; if (fwd_s !== 4'd0) begin fails++; $display("FAIL x0_fwd got %0h exp 0", fwd_s); end
    do_reset();
    set_id(1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); step();
    set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd9, 5'd3, 2'b10);
    tests++; if (stall_s !== 1'b0) begin fails++; $display("FAIL nouse_stall got %0b exp 0", stall_s); end
    step();
    tests++; if (fwd_s !== 4'd0) begin fails++; $display("FAIL nouse_fwd got %0h exp 0", fwd_s); end
  endtask

  task automatic test_saturate();
    do_reset();
    // A load that reads its own destination stalls on every other cycle.
    set_id(1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 5'd0, 2'b01);
    repeat (40) step();
    tests++; if (cnt3 !== 4'hF) begin fails++; $display("FAIL sat_cnt4 got %0d exp 15", cnt3); end
    tests++; if (cnt_s !== 32'd20) begin fails++; $display("FAIL sat_cnt32 got %0d exp 20", cnt_s); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); step();
    set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd0, 2'b01);
    tests++; if (stall_s !== 1'b1) begin fails++; $display("FAIL rms_pre got %0b exp 1", stall_s); end
    step();
    set_id(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00); step();
    set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd0, 2'b01);
    rst = 1'b1; step(); rst = 1'b0; #1;
    tests++; if (stall_s !== 1'b0) begin fails++; $display("FAIL rms_stall got %0b exp 0", stall_s); end
    tests++; if (cnt_s !== 32'd0) begin fails++; $display("FAIL rms_cnt got %0d exp 0", cnt_s); end
    tests++; if (fwd_s !== 4'd0) begin fails++; $display("FAIL rms_fwd got %0h exp 0", fwd_s); end
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_rd = 5'd0; id_regwr = 1'b0; id_memrd = 1'b0; id_rs = 10'd0; id_use = 2'b00;
    test_reset();
    test_fwd_ex();
    test_fwd_mem_wb();
    test_load_use();
    test_load_use_l2();
    test_youngest();
    test_flush();
    test_hold();
    test_x0_and_use();
    test_saturate();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
